// File: rtl/tdc_timestamp_fifo.sv
// tdc_timestamp_fifo
// Joins each fine TDC code with a latency-compensated coarse count to form a
// timestamp word. Words are buffered in a first-word-fall-through FIFO and
// handed to readout over a valid/ready handshake. Events lost to a full FIFO
// are tracked by a sticky overflow flag and a saturating drop counter.
module tdc_timestamp_fifo #(
  parameter int FINE_BITS   = 8,
  parameter int COARSE_BITS = 16,
  parameter int PIPE_LAT    = 4,
  parameter int DEPTH_LOG2  = 4,
  parameter int DROP_BITS   = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              fine_valid,
  input  logic [FINE_BITS-1:0]              value_fine,
  output logic [COARSE_BITS+FINE_BITS-1:0]  ts_data,
  output logic                              ts_valid,
  input  logic                              ts_ready,
  output logic [DEPTH_LOG2:0]               fill_level,
  output logic                              overflow,
  output logic [DROP_BITS-1:0]              drop_count,
  input  logic                              clear_status
);

  localparam int WORD_BITS = COARSE_BITS + FINE_BITS;
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int PTR_BITS  = DEPTH_LOG2 + 1;

  localparam logic [COARSE_BITS-1:0] LAT_C    = COARSE_BITS'(PIPE_LAT);
  localparam logic [DROP_BITS-1:0]   DROP_MAX = {DROP_BITS{1'b1}};

  // Registered state
  logic [COARSE_BITS-1:0] coarse_q, coarse_d;
  logic [PTR_BITS-1:0]    wptr_q, wptr_d;
  logic [PTR_BITS-1:0]    rptr_q, rptr_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_BITS-1:0]   drop_q, drop_d;
  logic [WORD_BITS-1:0]   mem_q [DEPTH];
  logic [WORD_BITS-1:0]   mem_d [DEPTH];

  // Decoded FIFO conditions and handshake events
  logic                   empty;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [COARSE_BITS-1:0] coarse_adj;
  logic [WORD_BITS-1:0]   new_word;
  logic [DEPTH_LOG2-1:0]  widx;
  logic [DEPTH_LOG2-1:0]  ridx;

  // Occupancy decode, handshake qualification and timestamp assembly
  always_comb begin
    widx       = wptr_q[DEPTH_LOG2-1:0];
    ridx       = rptr_q[DEPTH_LOG2-1:0];
    empty      = (wptr_q == rptr_q);
    full       = (wptr_q[PTR_BITS-1] != rptr_q[PTR_BITS-1]) && (widx == ridx);
    pop        = !empty && ts_ready;
    push       = fine_valid && (!full || pop);
    drop       = fine_valid && full && !pop;
    coarse_adj = coarse_q - LAT_C;
    new_word   = {coarse_adj, value_fine};
  end

  // Free-running coarse counter, wrapping silently
  always_comb begin
    coarse_d = coarse_q + 1'b1;
  end

  // Pointer advance on accepted push and pop
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // Storage write; the slot under the write pointer takes the new word
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[widx] = new_word;
    end
  end

  // Overflow/drop bookkeeping; a drop in the same cycle as a clear wins
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clear_status) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_d != DROP_MAX) begin
        drop_d = drop_d + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      coarse_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      coarse_q   <= coarse_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Outputs are decoded purely from registered state
  always_comb begin
    ts_valid   = (wptr_q != rptr_q);
    ts_data    = ts_valid ? mem_q[rptr_q[DEPTH_LOG2-1:0]] : '0;
    fill_level = wptr_q - rptr_q;
    overflow   = overflow_q;
    drop_count = drop_q;
  end

endmodule
